// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry, a log2 helper and
// the pointer-width macro used by the sibling async FIFO.
`ifndef FIFO_PTR_W
`define FIFO_PTR_W(depth) ($clog2(depth) + 1)
`endif

package fifo_pkg;

    localparam int FIFO_DATA_W_DEF = 8;
    localparam int FIFO_DEPTH_DEF  = 16;

    function automatic int fifo_clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read-first
// read port. The array itself is never reset.
module fifo_dp_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF,
    parameter int ADDR_W = fifo_clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Non-blocking update of mem keeps the read path read-first.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with occupancy count, programmable almost
// flags, sticky overflow/underflow and a registered read port.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF,
    parameter int ADDR_W = fifo_clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    input  logic [ADDR_W:0]   af_level,
    input  logic [ADDR_W:0]   ae_level,
    input  logic              flag_clr,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              fifo_almost_full,
    output logic              fifo_almost_empty,
    output logic              fifo_overflow,
    output logic              fifo_underflow
);

    localparam int PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic             rd_valid_q, rd_valid_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic full, empty;
    logic wr_ok, rd_ok;
    logic ovf_evt, udf_evt;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                   (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);

    // A full FIFO still accepts a write when a read frees a slot.
    assign rd_ok   = rd & ~empty;
    assign wr_ok   = wr & (~full | rd);
    assign ovf_evt = wr & ~wr_ok;
    assign udf_evt = rd & empty;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        rd_valid_d = rd_ok;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        if (wr_ok) begin
            wptr_d = wptr_q + {{ADDR_W{1'b0}}, 1'b1};
        end
        if (rd_ok) begin
            rptr_d = rptr_q + {{ADDR_W{1'b0}}, 1'b1};
        end
        if (ovf_evt) begin
            ovf_d = 1'b1;
        end else if (flag_clr) begin
            ovf_d = 1'b0;
        end
        if (udf_evt) begin
            udf_d = 1'b1;
        end else if (flag_clr) begin
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    fifo_dp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_ok),
        .waddr (wptr_q[ADDR_W-1:0]),
        .wdata (data_in),
        .re    (rd_ok),
        .raddr (rptr_q[ADDR_W-1:0]),
        .rdata (data_out)
    );

    assign fifo_count        = wptr_q - rptr_q;
    assign fifo_full         = full;
    assign fifo_empty        = empty;
    assign fifo_almost_full  = (fifo_count >= af_level);
    assign fifo_almost_empty = (fifo_count <= ae_level);
    assign fifo_overflow     = ovf_q;
    assign fifo_underflow    = udf_q;
    assign rd_valid          = rd_valid_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: queue-based reference model checked
// every cycle, directed scenarios and a randomized soak.
module tb_param_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr;
    logic [DW-1:0] data_in;
    logic          rd;
    logic [DW-1:0] data_out;
    logic          rd_valid;
    logic [AW:0]   af_level;
    logic [AW:0]   ae_level;
    logic          flag_clr;
    logic [AW:0]   fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_almost_full;
    logic          fifo_almost_empty;
    logic          fifo_overflow;
    logic          fifo_underflow;

    param_sync_fifo #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .wr                (wr),
        .data_in           (data_in),
        .rd                (rd),
        .data_out          (data_out),
        .rd_valid          (rd_valid),
        .af_level          (af_level),
        .ae_level          (ae_level),
        .flag_clr          (flag_clr),
        .fifo_count        (fifo_count),
        .fifo_full         (fifo_full),
        .fifo_empty        (fifo_empty),
        .fifo_almost_full  (fifo_almost_full),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_overflow     (fifo_overflow),
        .fifo_underflow    (fifo_underflow)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of words plus expected flags.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_rv;
    logic          m_ovf;
    logic          m_udf;

    always @(posedge clk or posedge reset) begin
        bit emp, ful, rok, wok;
        if (reset) begin
            q.delete();
            m_dout = '0;
            m_rv   = 1'b0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            emp = (q.size() == 0);
            ful = (q.size() == DEPTH);
            rok = rd && !emp;
            wok = wr && (!ful || rd);
            m_rv = rok;
            if (rok) m_dout = q.pop_front();
            if (wok) q.push_back(data_in);
            if (wr && !wok) m_ovf = 1'b1;
            else if (flag_clr) m_ovf = 1'b0;
            if (rd && emp) m_udf = 1'b1;
            else if (flag_clr) m_udf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("count", 32'(fifo_count), 32'(q.size()));
            chk("full", 32'(fifo_full), 32'(q.size() == DEPTH));
            chk("empty", 32'(fifo_empty), 32'(q.size() == 0));
            chk("almost_full", 32'(fifo_almost_full),
                32'(q.size() >= int'(af_level)));
            chk("almost_empty", 32'(fifo_almost_empty),
                32'(q.size() <= int'(ae_level)));
            chk("overflow", 32'(fifo_overflow), 32'(m_ovf));
            chk("underflow", 32'(fifo_underflow), 32'(m_udf));
            chk("rd_valid", 32'(rd_valid), 32'(m_rv));
            chk("data_out", 32'(data_out), 32'(m_dout));
        end
    end

    task automatic step(input bit w, input logic [DW-1:0] d,
                        input bit r, input bit c);
        wr       = w;
        data_in  = d;
        rd       = r;
        flag_clr = c;
        @(posedge clk);
        #1;
        wr       = 1'b0;
        rd       = 1'b0;
        flag_clr = 1'b0;
    endtask

    initial begin
        int peak;
        int got;
        int pw;
        int pr;
        wr       = 1'b0;
        rd       = 1'b0;
        flag_clr = 1'b0;
        data_in  = '0;
        af_level = 5'd14;
        ae_level = 5'd2;
        reset    = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_flags", 32'({fifo_overflow, fifo_underflow}), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Fill to full
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            chk("fill_count", 32'(fifo_count), 32'(i + 1));
            chk("fill_af", 32'(fifo_almost_full), 32'(i + 1 >= 14));
        end
        chk("fill_full", 32'(fifo_full), 32'd1);
        chk("fill_ovf", 32'(fifo_overflow), 32'd0);

        // Write while full without read
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_set", 32'(fifo_overflow), 32'd1);
        chk("ovf_count", 32'(fifo_count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_valid", 32'(rd_valid), 32'd1);
            chk("drain_data", 32'(data_out), 32'(i));
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("idle_valid", 32'(rd_valid), 32'd0);
        chk("idle_hold", 32'(data_out), 32'h0F);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(fifo_overflow), 32'd0);

        // Full with simultaneous write and read
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        chk("fwr_data", 32'(data_out), 32'h00);
        chk("fwr_count", 32'(fifo_count), 32'd16);
        chk("fwr_ovf", 32'(fifo_overflow), 32'd0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fwr_last", 32'(data_out), 32'h55);
        chk("fwr_empty", 32'(fifo_empty), 32'd1);

        // Underflow and set-wins-over-clear
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("udf_set", 32'(fifo_underflow), 32'd1);
        chk("udf_valid", 32'(rd_valid), 32'd0);
        chk("udf_hold", 32'(data_out), 32'h55);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("udf_set_wins", 32'(fifo_underflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("udf_clr", 32'(fifo_underflow), 32'd0);

        // Empty + wr + rd: write taken, read rejected
        step(1'b1, 8'h77, 1'b1, 1'b0);
        chk("ewr_count", 32'(fifo_count), 32'd1);
        chk("ewr_udf", 32'(fifo_underflow), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("ewr_data", 32'(data_out), 32'h77);
        chk("ewr_udf_clr", 32'(fifo_underflow), 32'd0);

        // Streaming across pointer wrap, read lagging by 3 cycles
        peak = 0;
        got  = 0;
        for (int i = 0; i < 43; i++) begin
            step(i < 40, 8'(8'h30 + i), i >= 3, 1'b0);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (rd_valid) begin
                chk("stream_data", 32'(data_out), 32'(8'h30 + got));
                got++;
            end
        end
        chk("stream_peak", 32'(peak), 32'd3);
        chk("stream_got", 32'(got), 32'd40);
        chk("stream_flags", 32'({fifo_overflow, fifo_underflow}), 32'd0);
        chk("stream_empty", 32'(fifo_empty), 32'd1);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_rst_count", 32'(fifo_count), 32'd7);
        chk("pre_rst_valid", 32'(rd_valid), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("arst_empty", 32'(fifo_empty), 32'd1);
        chk("arst_count", 32'(fifo_count), 32'd0);
        chk("arst_valid", 32'(rd_valid), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_data", 32'(data_out), 32'h11);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Threshold corner cases
        af_level = 5'd0;
        ae_level = 5'd16;
        #1;
        chk("af_zero", 32'(fifo_almost_full), 32'd1);
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("ae_depth", 32'(fifo_almost_empty), 32'd1);
        af_level = 5'd16;
        ae_level = 5'd15;
        #1;
        chk("af_full", 32'(fifo_almost_full), 32'd1);
        chk("ae_full", 32'(fifo_almost_empty), 32'd0);

        // Randomized soak with varying write/read bias
        for (int b = 0; b < 12; b++) begin
            pw = int'($urandom_range(10, 90));
            pr = int'($urandom_range(10, 90));
            af_level = 5'($urandom_range(0, 17));
            ae_level = 5'($urandom_range(0, 17));
            for (int i = 0; i < 50; i++) begin
                step(int'($urandom_range(0, 99)) < pw, 8'($urandom),
                     int'($urandom_range(0, 99)) < pr,
                     $urandom_range(0, 15) == 0);
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
